bist_march_ctrl: RTL and testbench
==================================

// Module: bist_march_ctrl
// PURPOSE
//  March C- BIST sequencer and response checker for the 256x4b SRAM.
//  Drives the SRAM address, data, and read/write strobes, and compares read data against expected values.
//  Issues a one-cycle fail_set pulse on each mismatch; fail_set drives the set input of the sticky Go/NoGo flip-flop.
//  Records the address of the first failure and signals completion.
// PARAMETERS
//  ADDR_W  8  SRAM address width; depth = 2**ADDR_W
//  DATA_W  4  SRAM word width; backgrounds are all-0 / all-1
// PORTS
//  clk         in   1       single clock; all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       begin test; sampled only in IDLE/DONE
//  mem_dout    in   DATA_W  SRAM read data, valid 1 cycle after mem_re
//  mem_addr    out  ADDR_W  SRAM address
//  mem_din     out  DATA_W  SRAM write data
//  mem_we      out  1       SRAM write strobe
//  mem_re      out  1       SRAM read strobe
//  busy        out  1       high from start acceptance through drain
//  done        out  1       level; high from completion until next start or rst
//  fail_set    out  1       1-cycle pulse per mismatching read; goes to the sticky flag's set input
//  fail_valid  out  1       sticky; a mismatch occurred in this run
//  fail_addr   out  ADDR_W  address of first mismatch; holds while fail_valid=1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pipeline valid bits cleared. Reset mid-run aborts in the same edge, with mem_we/mem_re low the next cycle.
//  States: IDLE -> RUN (start=1) -> DRAIN (2 cycles) -> DONE; DONE -> RUN on start=1.
//  Start handling: start is ignored while busy. A start accepted in IDLE/DONE clears done, fail_valid and fail_addr.
//  March elements, in order (E0-E5):
//   E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
//  Address sweep: "up" runs 0..2**ADDR_W-1; "down" runs 2**ADDR_W-1..0, wrapping via the counter terminal value.
//  Op timing: exactly one memory op per cycle, with no idle cycles between elements.
//   - 2-op elements: read cycle, then write cycle at the same address, then next address.
//  Op count: 256 + 4*512 + 256 = 2560 op cycles (ADDR_W=8).
//  Timing for a start sampled at edge E:
//   - busy=1 and the first op is presented from E.
//   - The last op is presented on cycle E+2559.
//   - done=1 and busy=0 after edge E+2562.
//  Check pipeline:
//   - Issue: on a read cycle, register exp_data (all-0/all-1 per element) and the address, with valid=1.
//   - Compare: on the next cycle, compare mem_dout against exp_data.
//   - Output: the mismatch is registered, so fail_set pulses 2 cycles after mem_re.
//  First-fail capture: on the first fail_set of a run, capture fail_addr and set fail_valid. Later fails pulse fail_set only.
//  Strobes: mem_we and mem_re are never both high. mem_din is 0 on non-write cycles.
//  DRAIN: 2 cycles that let the last compare retire, so done never precedes a fail_set of the same run.
// STRUCTURE
//  Package bist_pkg:
//   - state enum {IDLE,RUN,DRAIN,DONE}
//   - element table: direction, op count, read value, write value for E0-E5
//   - NUM_ELEM=6
//  Sub-module bist_addr_gen: ADDR_W up/down counter with load and a terminal-count flag.
//  Everything else (element/op index FSM, check pipeline, first-fail capture) lives in this module.
// TESTING
//  1. Fault-free 256x4 sync-read SRAM model; start pulse at edge E -> 2560 ops in March C- order, fail_set never high, done=1 after E+2562.
//  2. Bit 2 of addr 0x5A stuck-at-0 -> first fail_set is on E2's r1 of 0x5A, fail_addr=0x5A, fail_valid=1. Further pulses follow at E4 and the run completes.
//  3. Address order check -> E3's first op is a read of 0xFF, E3's last op is a write to 0x00, and E5 ends at 0xFF.
//  4. start held high for the whole run -> no restart while busy. A new run begins on the first start sampled in DONE, and that run clears fail_valid.
//  5. rst asserted at op cycle 1000 -> next cycle all outputs 0, state IDLE. A following start runs a full 2560-op test.
//  6. Strobe/data check every cycle -> never mem_we&&mem_re; mem_din is 0 or 4'hF only on writes, matching the element.

Source files
------------

// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bist_pkg
//  Brief    : Shared types and March C- element table for the SRAM BIST block.
//  Revision : 1.0  initial release
// ============================================================================
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_ELEM     = 6;
    localparam int ELEM_W       = 3;
    localparam int DRAIN_CYCLES = 2;

    // One march element. Two-op elements always run read then write.
    typedef struct packed {
        logic down;
        logic two_op;
        logic first_rd;
        logic rd_val;
        logic wr_val;
    } elem_t;

    function automatic elem_t elem_desc(input logic [ELEM_W-1:0] idx);
        elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_op: 1'b0, first_rd: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
            3'd1:    e = '{down: 1'b0, two_op: 1'b1, first_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            3'd2:    e = '{down: 1'b0, two_op: 1'b1, first_rd: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            3'd3:    e = '{down: 1'b1, two_op: 1'b1, first_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
            3'd4:    e = '{down: 1'b1, two_op: 1'b1, first_rd: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
            3'd5:    e = '{down: 1'b0, two_op: 1'b0, first_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic elem_down(input logic [ELEM_W-1:0] idx);
        elem_t e;
        e = elem_desc(idx);
        return e.down;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bist_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bist_addr_gen
//  Brief    : Loadable up/down address counter with a direction-aware
//             terminal-count flag.
//  Revision : 1.0  initial release
// ============================================================================
module bist_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_step,
    input  logic              i_down,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_step) begin
            r_addr <= i_down ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
        end
    end

    assign o_addr = r_addr;
    assign o_tc   = i_down ? (r_addr == '0) : (r_addr == '1);

endmodule
`default_nettype wire

// File: rtl/bist_march_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bist_march_ctrl
//  Brief    : March C- BIST sequencer and response checker for a sync-read
//             SRAM; reports the first failing address and a per-miss pulse.
//  Revision : 1.0  initial release
// ============================================================================
module bist_march_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    output logic              busy,
    output logic              done,
    output logic              fail_set,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr
);
    import bist_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [ELEM_W-1:0] r_elem;
    logic [ELEM_W-1:0] w_elem_idx_nxt;
    logic              r_phase;
    logic              r_drain_cnt;
    elem_t             w_elem;

    logic [ADDR_W-1:0] w_addr;
    logic              w_tc;
    logic              w_ag_load;
    logic              w_ag_step;
    logic [ADDR_W-1:0] w_ag_load_val;

    logic              w_run;
    logic              w_start_ok;
    logic              w_rd_op;
    logic              w_wr_op;
    logic              w_addr_done;
    logic              w_last_elem;

    logic              r_chk_valid;
    logic [DATA_W-1:0] r_chk_exp;
    logic [ADDR_W-1:0] r_chk_addr;
    logic              w_mismatch;
    logic              r_fail_set;
    logic              r_fail_valid;
    logic [ADDR_W-1:0] r_fail_addr;

    assign w_elem         = elem_desc(r_elem);
    assign w_elem_idx_nxt = r_elem + ELEM_W'(1);
    assign w_run          = (r_state == RUN);
    assign w_start_ok     = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_rd_op        = w_run && !r_phase && w_elem.first_rd;
    assign w_wr_op        = w_run && (r_phase || !w_elem.first_rd);
    assign w_addr_done    = !w_elem.two_op || r_phase;
    assign w_last_elem    = (r_elem == ELEM_W'(NUM_ELEM - 1));

    bist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ag_load),
        .i_load_val (w_ag_load_val),
        .i_step     (w_ag_step),
        .i_down     (w_elem.down),
        .o_addr     (w_addr),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, address-generator control and memory-side outputs.
    always_comb begin
        w_state_next  = r_state;
        w_ag_load     = 1'b0;
        w_ag_load_val = '0;
        w_ag_step     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        mem_we        = w_wr_op;
        mem_re        = w_rd_op;
        mem_addr      = w_run ? w_addr : '0;
        mem_din       = w_wr_op ? {DATA_W{w_elem.wr_val}} : '0;
        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (start) begin
                    w_state_next  = RUN;
                    w_ag_load     = 1'b1;
                    w_ag_load_val = elem_down(ELEM_W'(0)) ? '1 : '0;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_addr_done) begin
                    if (!w_tc) begin
                        w_ag_step = 1'b1;
                    end else if (w_last_elem) begin
                        w_state_next = DRAIN;
                    end else begin
                        // Preload the next element's first address so elements abut.
                        w_ag_load     = 1'b1;
                        w_ag_load_val = elem_down(w_elem_idx_nxt) ? '1 : '0;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt == 1'(DRAIN_CYCLES - 1)) begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_elem      <= '0;
            r_phase     <= 1'b0;
            r_drain_cnt <= 1'b0;
        end else begin
            r_drain_cnt <= (r_state == DRAIN) ? (r_drain_cnt + 1'b1) : 1'b0;
            if (w_start_ok) begin
                r_elem  <= '0;
                r_phase <= 1'b0;
            end else if (w_run) begin
                if (!w_addr_done) begin
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (w_tc && !w_last_elem) begin
                        r_elem <= w_elem_idx_nxt;
                    end
                end
            end
        end
    end

    // Read data returns one cycle after the strobe; the verdict is registered once more.
    assign w_mismatch = r_chk_valid && (mem_dout != r_chk_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_valid  <= 1'b0;
            r_chk_exp    <= '0;
            r_chk_addr   <= '0;
            r_fail_set   <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_addr  <= '0;
        end else begin
            r_chk_valid <= w_rd_op;
            if (w_rd_op) begin
                r_chk_exp  <= {DATA_W{w_elem.rd_val}};
                r_chk_addr <= w_addr;
            end
            r_fail_set <= w_mismatch;
            if (w_start_ok) begin
                r_fail_valid <= 1'b0;
                r_fail_addr  <= '0;
            end else if (w_mismatch && !r_fail_valid) begin
                r_fail_valid <= 1'b1;
                r_fail_addr  <= r_chk_addr;
            end
        end
    end

    assign fail_set   = r_fail_set;
    assign fail_valid = r_fail_valid;
    assign fail_addr  = r_fail_addr;

endmodule
`default_nettype wire

// File: tb/tb_bist_march_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bist_march_ctrl
//  Brief    : Directed bench for the March C- controller with a sync-read
//             256x4 SRAM model and an optional stuck-at-0 cell.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] mem_dout = 4'h0;
    logic [7:0] mem_addr;
    logic [3:0] mem_din;
    logic       mem_we;
    logic       mem_re;
    logic       busy;
    logic       done;
    logic       fail_set;
    logic       fail_valid;
    logic [7:0] fail_addr;

    int   total = 0;
    int   bad   = 0;
    logic fault_on = 1'b0;
    logic [3:0] sram [0:255];

    always #5 clk = ~clk;

    bist_march_ctrl #(
        .ADDR_W (8),
        .DATA_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_dout   (mem_dout),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .busy       (busy),
        .done       (done),
        .fail_set   (fail_set),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr)
    );

    // Sync-read SRAM; the fault forces bit 2 of address 0x5A to read as 0.
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_din;
        if (mem_re) mem_dout <= (fault_on && mem_addr == 8'h5A) ? (sram[mem_addr] & 4'hB) : sram[mem_addr];
    end

    // Op k of a March C- run on 256 words, derived from the element layout.
    function automatic void exp_op(input int k, output logic we, output logic re,
                                   output logic [7:0] a, output logic [3:0] d);
        int e;
        int j;
        int s;
        we = 1'b0; re = 1'b0; a = 8'h00; d = 4'h0;
        if (k < 256) begin
            we = 1'b1; a = 8'(k);
        end else if (k < 2304) begin
            e = (k - 256) / 512 + 1;
            j = (k - 256) % 512;
            s = j / 2;
            a = (e >= 3) ? 8'(255 - s) : 8'(s);
            if (j % 2 == 0) re = 1'b1;
            else begin
                we = 1'b1;
                d  = (e == 1 || e == 3) ? 4'hF : 4'h0;
            end
        end else begin
            re = 1'b1; a = 8'(k - 2304);
        end
    endfunction

    // Start pulse; returns at the negedge of op cycle 0.
    task automatic go();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_addr, mem_din, mem_we, mem_re, busy, done, fail_set, fail_valid, fail_addr} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs got addr=%h din=%h we=%b re=%b busy=%b done=%b fs=%b fv=%b fa=%h want all 0",
                     mem_addr, mem_din, mem_we, mem_re, busy, done, fail_set, fail_valid, fail_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, mem_we, mem_re} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b we=%b re=%b want 0", busy, done, mem_we, mem_re);
        end
    endtask

    task automatic test_full_run();
        logic ewe, ere;
        logic [7:0] ea;
        logic [3:0] ed;
        go();
        for (int c = 0; c < 2563; c++) begin
            if (c < 2560) begin
                exp_op(c, ewe, ere, ea, ed);
                total++;
                if ({mem_we, mem_re, mem_addr, mem_din} !== {ewe, ere, ea, ed}) begin
                    bad++;
                    $display("FAIL full_op c=%0d got we=%b re=%b a=%h d=%h want we=%b re=%b a=%h d=%h",
                             c, mem_we, mem_re, mem_addr, mem_din, ewe, ere, ea, ed);
                end
                total++;
                if ({busy, done} !== 2'b10) begin
                    bad++;
                    $display("FAIL full_busy c=%0d got busy=%b done=%b want 1 0", c, busy, done);
                end
            end else if (c < 2562) begin
                total++;
                if ({busy, done, mem_we, mem_re} !== 4'b1000) begin
                    bad++;
                    $display("FAIL full_drain c=%0d got busy=%b done=%b we=%b re=%b want 1 0 0 0", c, busy, done, mem_we, mem_re);
                end
            end else begin
                total++;
                if ({busy, done} !== 2'b01) begin
                    bad++;
                    $display("FAIL full_done c=%0d got busy=%b done=%b want 0 1", c, busy, done);
                end
            end
            total++;
            if ((mem_we & mem_re) !== 1'b0 || fail_set !== 1'b0) begin
                bad++;
                $display("FAIL full_strobe c=%0d got we&re=%b fail_set=%b want 0 0", c, mem_we & mem_re, fail_set);
            end
            @(negedge clk);
        end
        total++;
        if (fail_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_fail_valid got %b want 0", fail_valid);
        end
    endtask

    task automatic test_addr_order();
        go();
        for (int c = 0; c < 2563; c++) begin
            if (c == 1280) begin
                total++;
                if ({mem_re, mem_we, mem_addr} !== {2'b10, 8'hFF}) begin
                    bad++;
                    $display("FAIL e3_first got re=%b we=%b a=%h want re=1 we=0 a=ff", mem_re, mem_we, mem_addr);
                end
            end
            if (c == 1791) begin
                total++;
                if ({mem_re, mem_we, mem_addr, mem_din} !== {2'b01, 8'h00, 4'hF}) begin
                    bad++;
                    $display("FAIL e3_last got re=%b we=%b a=%h d=%h want re=0 we=1 a=00 d=f", mem_re, mem_we, mem_addr, mem_din);
                end
            end
            if (c == 1792) begin
                total++;
                if ({mem_re, mem_we, mem_addr} !== {2'b10, 8'hFF}) begin
                    bad++;
                    $display("FAIL e4_first got re=%b we=%b a=%h want re=1 we=0 a=ff", mem_re, mem_we, mem_addr);
                end
            end
            if (c == 2559) begin
                total++;
                if ({mem_re, mem_we, mem_addr} !== {2'b10, 8'hFF}) begin
                    bad++;
                    $display("FAIL e5_last got re=%b we=%b a=%h want re=1 we=0 a=ff", mem_re, mem_we, mem_addr);
                end
            end
            if (c == 2560) begin
                total++;
                if ({mem_re, mem_we} !== 2'b00) begin
                    bad++;
                    $display("FAIL after_last got re=%b we=%b want 0 0", mem_re, mem_we);
                end
            end
            if (c == 2562) begin
                total++;
                if (done !== 1'b1) begin
                    bad++;
                    $display("FAIL order_done got %b want 1", done);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stuck_fault();
        int first;
        int second;
        int npulse;
        first = -1; second = -1; npulse = 0;
        fault_on = 1'b1;
        go();
        for (int c = 0; c < 2563; c++) begin
            if (fail_set === 1'b1) begin
                npulse++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (c == 949) begin
                total++;
                if (fail_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL fv_before got %b want 0", fail_valid);
                end
            end
            if (c == 951) begin
                total++;
                if ({fail_valid, fail_addr} !== {1'b1, 8'h5A}) begin
                    bad++;
                    $display("FAIL fv_after got fv=%b fa=%h want 1 5a", fail_valid, fail_addr);
                end
            end
            if (c == 2562) begin
                total++;
                if ({busy, done} !== 2'b01) begin
                    bad++;
                    $display("FAIL stuck_done got busy=%b done=%b want 0 1", busy, done);
                end
            end
            @(negedge clk);
        end
        total++;
        if (first !== 950) begin
            bad++;
            $display("FAIL first_fail_cycle got %0d want 950", first);
        end
        total++;
        if (second !== 2124) begin
            bad++;
            $display("FAIL second_fail_cycle got %0d want 2124", second);
        end
        total++;
        if (npulse !== 2) begin
            bad++;
            $display("FAIL fail_pulses got %0d want 2", npulse);
        end
        total++;
        if ({fail_valid, fail_addr} !== {1'b1, 8'h5A}) begin
            bad++;
            $display("FAIL stuck_capture got fv=%b fa=%h want 1 5a", fail_valid, fail_addr);
        end
        fault_on = 1'b0;
    endtask

    task automatic test_start_held();
        logic ewe, ere;
        logic [7:0] ea;
        logic [3:0] ed;
        int nbusy_bad;
        int seen;
        nbusy_bad = 0; seen = -1;
        fault_on = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 2564; c++) begin
            if (c > 0 && c < 2562 && busy !== 1'b1) nbusy_bad++;
            if (c == 1000) begin
                exp_op(c, ewe, ere, ea, ed);
                total++;
                if ({mem_we, mem_re, mem_addr, mem_din} !== {ewe, ere, ea, ed}) begin
                    bad++;
                    $display("FAIL held_op1000 got we=%b re=%b a=%h d=%h want we=%b re=%b a=%h d=%h",
                             mem_we, mem_re, mem_addr, mem_din, ewe, ere, ea, ed);
                end
            end
            if (c == 2562) begin
                total++;
                if ({done, busy, fail_valid} !== 3'b101) begin
                    bad++;
                    $display("FAIL held_done got done=%b busy=%b fv=%b want 1 0 1", done, busy, fail_valid);
                end
                fault_on = 1'b0;
            end
            if (c == 2563) begin
                total++;
                if ({busy, done, fail_valid, mem_we, mem_addr} !== {4'b1001, 8'h00}) begin
                    bad++;
                    $display("FAIL held_restart got busy=%b done=%b fv=%b we=%b a=%h want 1 0 0 1 00",
                             busy, done, fail_valid, mem_we, mem_addr);
                end
                start = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (nbusy_bad !== 0) begin
            bad++;
            $display("FAIL held_busy got %0d non-busy cycles want 0", nbusy_bad);
        end
        for (int c = 1; c < 2700; c++) begin
            if (done === 1'b1) begin
                seen = c;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (seen !== 2562) begin
            bad++;
            $display("FAIL held_second_done got cycle %0d want 2562", seen);
        end
        total++;
        if (fail_valid !== 1'b0) begin
            bad++;
            $display("FAIL held_second_fv got %b want 0", fail_valid);
        end
    endtask

    task automatic test_reset_midrun();
        int nops;
        int nfs;
        nops = 0; nfs = 0;
        fault_on = 1'b1;
        go();
        repeat (1000) @(negedge clk);
        total++;
        if (fail_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_fv got %b want 1", fail_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_addr, mem_din, mem_we, mem_re, busy, done, fail_set, fail_valid, fail_addr} !== 26'd0) begin
            bad++;
            $display("FAIL midrun_reset got addr=%h din=%h we=%b re=%b busy=%b done=%b fs=%b fv=%b fa=%h want all 0",
                     mem_addr, mem_din, mem_we, mem_re, busy, done, fail_set, fail_valid, fail_addr);
        end
        rst = 1'b0;
        fault_on = 1'b0;
        go();
        for (int c = 0; c < 2563; c++) begin
            if (mem_we === 1'b1 || mem_re === 1'b1) nops++;
            if (fail_set === 1'b1) nfs++;
            if (c == 2562) begin
                total++;
                if ({busy, done} !== 2'b01) begin
                    bad++;
                    $display("FAIL rerun_done got busy=%b done=%b want 0 1", busy, done);
                end
            end
            @(negedge clk);
        end
        total++;
        if (nops !== 2560) begin
            bad++;
            $display("FAIL rerun_ops got %0d want 2560", nops);
        end
        total++;
        if ({nfs != 0, fail_valid} !== 2'b00) begin
            bad++;
            $display("FAIL rerun_clean got pulses=%0d fv=%b want 0 0", nfs, fail_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_addr_order();
        test_stuck_fault();
        test_start_held();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
